id_ex_decode_stage: RTL

Second-generation control path for the 5-stage pipeline. It decodes the IF/ID instruction into a control bundle and registers that bundle into the ID/EX pipeline register. It adds load-use hazard detection with stall/bubble, branch/jump flush, a parametrised immediate extender, shift and LUI support, and a saturating stall counter. It sits between the IF/ID register and the EX stage, and drives the IF/ID and PC write-enable through stall_o.

---
 rtl/cpu_ctrl_pkg.sv | 58 +++++
 rtl/id_ex_decode_stage_inst_decoder.sv | 117 +++++++++++
 rtl/id_ex_decode_stage.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/cpu_ctrl_pkg.sv
// Shared opcode/funct encodings, ALU op codes and the decoded control bundle
// used by the ID stage decoder and the ID/EX pipeline register.
package cpu_ctrl_pkg;

    localparam int ALU_CODE_W = 4;

    // Primary opcodes (inst[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    // R-type function codes (inst[5:0])
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // ALU operation codes seen by the EX stage
    localparam logic [ALU_CODE_W-1:0] ALU_ADD = 4'd0;
    localparam logic [ALU_CODE_W-1:0] ALU_SUB = 4'd1;
    localparam logic [ALU_CODE_W-1:0] ALU_AND = 4'd2;
    localparam logic [ALU_CODE_W-1:0] ALU_OR  = 4'd3;
    localparam logic [ALU_CODE_W-1:0] ALU_XOR = 4'd4;
    localparam logic [ALU_CODE_W-1:0] ALU_NOR = 4'd5;
    localparam logic [ALU_CODE_W-1:0] ALU_SLT = 4'd6;
    localparam logic [ALU_CODE_W-1:0] ALU_SLL = 4'd7;
    localparam logic [ALU_CODE_W-1:0] ALU_SRL = 4'd8;
    localparam logic [ALU_CODE_W-1:0] ALU_LUI = 4'd9;

    // rt_src marks instructions that read rt; it only feeds hazard detection.
    typedef struct packed {
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
        logic                  alu_src_b;
        logic                  beq;
        logic                  bne;
        logic                  jump;
        logic [ALU_CODE_W-1:0] alu_code;
        logic                  rt_src;
    } ctrl_t;

endpackage

// File: rtl/id_ex_decode_stage_inst_decoder.sv
// Purely combinational decode of one instruction word into the control bundle,
// register fields, illegal flag and the extended immediate.
module inst_decoder
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [31:0]       inst,
    output ctrl_t             ctrl,
    output logic              illegal,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic [4:0]        wr_addr,
    output logic [4:0]        shamt,
    output logic [DATA_W-1:0] imm
);

    logic [5:0] opcode;
    logic [5:0] funct;
    logic [4:0] rd;
    logic [4:0] dest;
    logic       write_rd;
    logic       zero_ext;

    assign opcode = inst[31:26];
    assign funct  = inst[5:0];
    assign rd     = inst[15:11];
    assign rs     = inst[25:21];
    assign rt     = inst[20:16];
    assign shamt  = inst[10:6];

    always_comb begin
        ctrl     = '0;
        illegal  = 1'b0;
        write_rd = 1'b0;
        zero_ext = 1'b0;
        dest     = '0;
        wr_addr  = '0;

        unique case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                ctrl.rt_src    = 1'b1;
                write_rd       = 1'b1;
                unique case (funct)
                    FN_ADD:  ctrl.alu_code = ALU_ADD;
                    FN_SUB:  ctrl.alu_code = ALU_SUB;
                    FN_AND:  ctrl.alu_code = ALU_AND;
                    FN_OR:   ctrl.alu_code = ALU_OR;
                    FN_XOR:  ctrl.alu_code = ALU_XOR;
                    FN_NOR:  ctrl.alu_code = ALU_NOR;
                    FN_SLT:  ctrl.alu_code = ALU_SLT;
                    FN_SLL:  ctrl.alu_code = ALU_SLL;
                    FN_SRL:  ctrl.alu_code = ALU_SRL;
                    default: illegal       = 1'b1;
                endcase
            end
            OP_BEQ: begin
                ctrl.beq      = 1'b1;
                ctrl.rt_src   = 1'b1;
                ctrl.alu_code = ALU_SUB;
            end
            OP_BNE: begin
                ctrl.bne      = 1'b1;
                ctrl.rt_src   = 1'b1;
                ctrl.alu_code = ALU_SUB;
            end
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
                ctrl.reg_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                unique case (opcode)
                    OP_ADDI: ctrl.alu_code = ALU_ADD;
                    OP_SLTI: ctrl.alu_code = ALU_SLT;
                    OP_ANDI: ctrl.alu_code = ALU_AND;
                    OP_ORI:  ctrl.alu_code = ALU_OR;
                    OP_XORI: ctrl.alu_code = ALU_XOR;
                    default: ctrl.alu_code = ALU_LUI;
                endcase
                // Logical immediates and LUI take the raw 16 bits.
                zero_ext = (opcode == OP_ANDI) || (opcode == OP_ORI) ||
                           (opcode == OP_XORI) || (opcode == OP_LUI);
            end
            OP_LW: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_read   = 1'b1;
                ctrl.mem_to_reg = 1'b1;
                ctrl.alu_src_b  = 1'b1;
                ctrl.alu_code   = ALU_ADD;
            end
            OP_SW: begin
                ctrl.mem_write = 1'b1;
                ctrl.alu_src_b = 1'b1;
                ctrl.rt_src    = 1'b1;
                ctrl.alu_code  = ALU_ADD;
            end
            OP_J: begin
                ctrl.jump = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl = '0;
        end

        dest = write_rd ? rd : rt;
        // Writes to $0 are dropped so that the all-zero word is a true NOP.
        if (dest == 5'd0) begin
            ctrl.reg_write = 1'b0;
        end
        wr_addr = ctrl.reg_write ? dest : 5'd0;
    end

    assign imm = zero_ext ? {{(DATA_W-16){1'b0}}, inst[15:0]}
                          : {{(DATA_W-16){inst[15]}}, inst[15:0]};

endmodule

// File: rtl/id_ex_decode_stage.sv
// ID stage control path: decode, load-use hazard detection with stall/bubble,
// flush handling, the ID/EX pipeline register and a saturating stall counter.
module id_ex_decode_stage
    import cpu_ctrl_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 5,
    parameter int ALU_W   = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [31:0]        id_inst,
    input  logic               flush_i,
    output logic               stall_o,
    output logic               ex_valid,
    output logic               ex_reg_write,
    output logic               ex_mem_read,
    output logic               ex_mem_write,
    output logic               ex_mem_to_reg,
    output logic               ex_alu_src_b,
    output logic               ex_beq,
    output logic               ex_bne,
    output logic               ex_jump,
    output logic [ALU_W-1:0]   ex_alu_code,
    output logic [RADDR_W-1:0] ex_rs,
    output logic [RADDR_W-1:0] ex_rt,
    output logic [RADDR_W-1:0] ex_wr_addr,
    output logic [4:0]         ex_shamt,
    output logic [DATA_W-1:0]  ex_imm,
    output logic               ex_illegal,
    output logic [CNT_W-1:0]   stall_cnt
);

    // Handshake: id_valid qualifies id_inst. stall_o is the inverse of ready
    // toward IF/ID; while it is high the producer must hold id_inst/id_valid
    // unchanged so the same instruction is re-presented next cycle.

    ctrl_t              dec_ctrl;
    logic               dec_illegal;
    logic [4:0]         dec_rs;
    logic [4:0]         dec_rt;
    logic [4:0]         dec_wr;
    logic [4:0]         dec_shamt;
    logic [DATA_W-1:0]  dec_imm;
    logic [RADDR_W-1:0] id_rs;
    logic [RADDR_W-1:0] id_rt;
    logic [RADDR_W-1:0] id_wr;
    logic               hazard;
    logic               load_bubble;

    inst_decoder #(
        .DATA_W (DATA_W)
    ) u_dec (
        .inst    (id_inst),
        .ctrl    (dec_ctrl),
        .illegal (dec_illegal),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .wr_addr (dec_wr),
        .shamt   (dec_shamt),
        .imm     (dec_imm)
    );

    assign id_rs = RADDR_W'(dec_rs);
    assign id_rt = RADDR_W'(dec_rt);
    assign id_wr = RADDR_W'(dec_wr);

    assign hazard = ex_valid && ex_mem_read && id_valid && (ex_wr_addr != '0) &&
                    ((ex_wr_addr == id_rs) || ((ex_wr_addr == id_rt) && dec_ctrl.rt_src));

    // A taken branch kills the dependent instruction anyway, so no stall.
    assign stall_o     = hazard && !flush_i;
    assign load_bubble = flush_i || hazard || !id_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src_b  <= 1'b0;
            ex_beq        <= 1'b0;
            ex_bne        <= 1'b0;
            ex_jump       <= 1'b0;
            ex_alu_code   <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_wr_addr    <= '0;
            ex_shamt      <= '0;
            ex_imm        <= '0;
            ex_illegal    <= 1'b0;
        end else if (load_bubble) begin
            ex_valid      <= 1'b0;
            ex_reg_write  <= 1'b0;
            ex_mem_read   <= 1'b0;
            ex_mem_write  <= 1'b0;
            ex_mem_to_reg <= 1'b0;
            ex_alu_src_b  <= 1'b0;
            ex_beq        <= 1'b0;
            ex_bne        <= 1'b0;
            ex_jump       <= 1'b0;
            ex_alu_code   <= '0;
            ex_rs         <= '0;
            ex_rt         <= '0;
            ex_wr_addr    <= '0;
            ex_shamt      <= '0;
            ex_imm        <= '0;
            ex_illegal    <= 1'b0;
        end else begin
            ex_valid      <= 1'b1;
            ex_reg_write  <= dec_ctrl.reg_write;
            ex_mem_read   <= dec_ctrl.mem_read;
            ex_mem_write  <= dec_ctrl.mem_write;
            ex_mem_to_reg <= dec_ctrl.mem_to_reg;
            ex_alu_src_b  <= dec_ctrl.alu_src_b;
            ex_beq        <= dec_ctrl.beq;
            ex_bne        <= dec_ctrl.bne;
            ex_jump       <= dec_ctrl.jump;
            ex_alu_code   <= ALU_W'(dec_ctrl.alu_code);
            ex_rs         <= id_rs;
            ex_rt         <= id_rt;
            ex_wr_addr    <= id_wr;
            ex_shamt      <= dec_shamt;
            ex_imm        <= dec_imm;
            ex_illegal    <= dec_illegal;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall_o && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule
